// File: rtl/mem_rmw_ctrl_if.sv
// Request-side bus between the multicycle datapath (master) and the
// load/store read-modify-write controller (slave).
interface mem_rmw_ctrl_if #(
  parameter int N = 32
);
  logic         req;
  logic         wr;
  logic [1:0]   size;
  logic         sgn;
  logic [N-1:0] addr;
  logic [N-1:0] wdata;
  logic         ready;
  logic         err;
  logic [N-1:0] rdata;

  modport master (
    output req, wr, size, sgn, addr, wdata,
    input  ready, err, rdata
  );

  modport slave (
    input  req, wr, size, sgn, addr, wdata,
    output ready, err, rdata
  );
endinterface

// File: rtl/mem_rmw_ctrl.sv
// Load/store front end for a word-addressed unified memory. Sub-word stores
// are done as read-modify-write, sub-word loads are lane-extracted and
// sign/zero-extended, misaligned or illegal accesses complete with err.
// Byte lanes are fixed at four, so N is expected to be 32.
module mem_rmw_ctrl #(
  parameter int N = 32
) (
  input  logic            clk,
  input  logic            reset,
  mem_rmw_ctrl_if.slave   bus,
  output logic [N-1:0]    mem_a,
  output logic            mem_we,
  output logic [N-1:0]    mem_wd,
  input  logic [N-1:0]    mem_rd
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    DONE,
    ERR
  } state_t;

  state_t       state;
  state_t       state_nxt;

  logic [N-1:0] addr_q;
  logic         wr_q;
  logic [1:0]   size_q;
  logic         sgn_q;
  logic [N-1:0] wdata_q;
  logic [N-1:0] word_q;
  logic [N-1:0] rdata_q;

  logic         accept;

  // Illegal size, or an address not aligned to the access size.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      SZ_WORD: bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Pick the addressed lane out of a memory word and extend it to N bits.
  function automatic logic [N-1:0] lane_extract(input logic [N-1:0] word,
                                                 input logic [1:0]   lo,
                                                 input logic [1:0]   sz,
                                                 input logic         sg);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [N-1:0]       r;
    b = $signed(word[{lo, 3'b000} +: 8]);
    h = lo[1] ? $signed(word[16 +: 16]) : $signed(word[0 +: 16]);
    case (sz)
      SZ_BYTE: r = sg ? {{(N-8){b[7]}}, b}   : {{(N-8){1'b0}}, b};
      SZ_HALF: r = sg ? {{(N-16){h[15]}}, h} : {{(N-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with right-aligned store data.
  function automatic logic [N-1:0] lane_merge(input logic [N-1:0] old,
                                               input logic [N-1:0] wd,
                                               input logic [1:0]   lo,
                                               input logic [1:0]   sz);
    logic [N-1:0] r;
    r = old;
    case (sz)
      SZ_BYTE: r[{lo, 3'b000} +: 8] = wd[7:0];
      SZ_HALF: begin
        if (lo[1]) r[16 +: 16] = wd[15:0];
        else       r[0 +: 16]  = wd[15:0];
      end
      SZ_WORD: r = wd;
      default: r = old;
    endcase
    return r;
  endfunction

  assign accept = (state == IDLE) && bus.req;

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state selection: stores that touch only part of a word read it first.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (misaligned(bus.size, bus.addr[1:0]))    state_nxt = ERR;
          else if (bus.wr && (bus.size == SZ_WORD))   state_nxt = WR;
          else                                        state_nxt = RD;
        end
      end
      RD:      state_nxt = wr_q ? WR : DONE;
      WR:      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, loaded only when a request is accepted in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.addr;
      wr_q    <= bus.wr;
      size_q  <= bus.size;
      sgn_q   <= bus.sgn;
      wdata_q <= bus.wdata;
    end
  end

  // Memory word captured in RD: load source, or old word for a merge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            word_q <= '0;
    else if (state == RD) word_q <= mem_rd;
  end

  // Load result register, updated on load completion and held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        rdata_q <= '0;
    else if ((state == DONE) && !wr_q) rdata_q <= lane_extract(word_q, addr_q[1:0], size_q, sgn_q);
  end

  // Completion, error and memory-side outputs decoded from state.
  always_comb begin
    bus.ready = 1'b0;
    bus.err   = 1'b0;
    mem_we    = 1'b0;
    mem_a     = {addr_q[N-1:2], 2'b00};
    mem_wd    = lane_merge(word_q, wdata_q, addr_q[1:0], size_q);
    case (state)
      WR:   mem_we = 1'b1;
      DONE: bus.ready = 1'b1;
      ERR: begin
        bus.ready = 1'b1;
        bus.err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Testbench for mem_rmw_ctrl: word memory model attached to the memory side,
// byte-addressed reference memory used to predict loads, merged words and errors.
module tb_mem_rmw_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  mem_rmw_ctrl_if #(.N(32)) bus();

  mem_rmw_ctrl #(.N(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .mem_a  (mem_a),
    .mem_we (mem_we),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  // Word memory seen by the DUT, with a backdoor port for preloading.
  logic [31:0] dmem [0:63];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_val;

  assign mem_rd = dmem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we)     dmem[mem_a[7:2]] <= mem_wd;
    else if (bd_we) dmem[bd_idx]     <= bd_val;
  end

  // Reference: memory as individual bytes, little-endian.
  logic [7:0]  rmem [0:255];
  logic [31:0] exp_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {rmem[b + 8'd3], rmem[b + 8'd2], rmem[b + 8'd1], rmem[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    logic [7:0]  ai;
    logic [15:0] h;
    int          v;
    ai = a[7:0];
    if (sz == 2'b00) begin
      v = int'(rmem[ai]);
      if (sg && v >= 128) v = v - 256;
      return 32'(v);
    end else if (sz == 2'b01) begin
      h = {rmem[ai + 8'd1], rmem[ai]};
      v = int'(h);
      if (sg && v >= 32768) v = v - 65536;
      return 32'(v);
    end
    return {rmem[ai + 8'd3], rmem[ai + 8'd2], rmem[ai + 8'd1], rmem[ai]};
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [7:0] ai;
    ai = a[7:0];
    rmem[ai] = wd[7:0];
    if (sz != 2'b00) rmem[ai + 8'd1] = wd[15:8];
    if (sz == 2'b10) begin
      rmem[ai + 8'd2] = wd[23:16];
      rmem[ai + 8'd3] = wd[31:24];
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    @(negedge clk);
    bd_we  = 1'b1;
    bd_idx = a[7:2];
    bd_val = w;
    @(negedge clk);
    bd_we  = 1'b0;
    for (int i = 0; i < 4; i++) rmem[{a[7:2], 2'b00} + 8'(i)] = w[8*i +: 8];
  endtask

  // Issue one request; report ready cycle (req cycle = 0), err, mem_we activity
  // and the rdata seen one cycle after completion. rcyc stays -1 on timeout.
  task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int rcyc, output logic e, output logic [31:0] rd,
                        output int wecnt, output int wecyc,
                        output logic [31:0] wdat, output logic [31:0] wa);
    rcyc  = -1;
    e     = 1'b0;
    wecnt = 0;
    wecyc = -1;
    wdat  = '0;
    wa    = '0;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.wr    = w;
    bus.size  = sz;
    bus.sgn   = sg;
    bus.addr  = a;
    bus.wdata = wd;
    for (int k = 1; k <= 8 && rcyc < 0; k++) begin
      @(negedge clk);
      if (mem_we) begin
        wecnt++;
        wecyc = k;
        wdat  = mem_wd;
        wa    = mem_a;
      end
      if (bus.ready) begin
        rcyc    = k;
        e       = bus.err;
        bus.req = 1'b0;
      end
    end
    bus.req = 1'b0;
    @(negedge clk);
    if (mem_we) wecnt++;
    rd = bus.rdata;
  endtask

  task automatic test_reset;
    tests_run++;
    if (bus.ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready: got %0b want 0", bus.ready); end
    tests_run++;
    if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %0b want 0", bus.err); end
    tests_run++;
    if (bus.rdata !== 32'h0) begin tests_failed++; $display("FAIL rst_rdata: got %08h want 00000000", bus.rdata); end
    tests_run++;
    if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
    tests_run++;
    if (mem_a !== 32'h0) begin tests_failed++; $display("FAIL rst_mem_a: got %08h want 00000000", mem_a); end
  endtask

  task automatic test_load;
    int rc, wc, wy; logic e; logic [31:0] rd, wd, wa;
    preload(32'h10, 32'h11223344);
    access(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rc, e, rd, wc, wy, wd, wa);
    tests_run++;
    if (rc !== 2) begin tests_failed++; $display("FAIL ld_byte_latency: got %0d want 2", rc); end
    tests_run++;
    if (rd !== 32'h00000011) begin tests_failed++; $display("FAIL ld_byte_rdata: got %08h want 00000011", rd); end
    tests_run++;
    if (wc !== 0 || e !== 1'b0) begin tests_failed++; $display("FAIL ld_byte_side: we_count %0d err %0b want 0 0", wc, e); end
    preload(32'h10, 32'h8899AABB);
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rc, e, rd, wc, wy, wd, wa);
    tests_run++;
    if (rd !== 32'hFFFF8899) begin tests_failed++; $display("FAIL ld_half_sext: got %08h want FFFF8899", rd); end
    tests_run++;
    if (rc !== 2) begin tests_failed++; $display("FAIL ld_half_latency: got %0d want 2", rc); end
    exp_rdata = 32'hFFFF8899;
  endtask

  task automatic test_subword_store;
    int rc, wc, wy; logic e; logic [31:0] rd, wd, wa;
    preload(32'h20, 32'h11223344);
    access(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000EE, rc, e, rd, wc, wy, wd, wa);
    ref_store(2'b00, 32'h21, 32'h000000EE);
    tests_run++;
    if (wc !== 1 || wy !== 2) begin tests_failed++; $display("FAIL sb_we_pulse: count %0d cycle %0d want 1 2", wc, wy); end
    tests_run++;
    if (wd !== 32'h1122EE44) begin tests_failed++; $display("FAIL sb_mem_wd: got %08h want 1122EE44", wd); end
    tests_run++;
    if (wa !== 32'h20) begin tests_failed++; $display("FAIL sb_mem_a: got %08h want 00000020", wa); end
    tests_run++;
    if (rc !== 3) begin tests_failed++; $display("FAIL sb_latency: got %0d want 3", rc); end
    tests_run++;
    if (rd !== exp_rdata) begin tests_failed++; $display("FAIL sb_rdata_held: got %08h want %08h", rd, exp_rdata); end
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rc, e, rd, wc, wy, wd, wa);
    tests_run++;
    if (rd !== 32'h1122EE44) begin tests_failed++; $display("FAIL sb_readback: got %08h want 1122EE44", rd); end
    exp_rdata = rd;
  endtask

  task automatic test_word_store;
    int rc, wc, wy; logic e; logic [31:0] rd, wd, wa;
    access(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, rc, e, rd, wc, wy, wd, wa);
    ref_store(2'b10, 32'h40, 32'hDEADBEEF);
    tests_run++;
    if (wc !== 1 || wy !== 1) begin tests_failed++; $display("FAIL sw_we_pulse: count %0d cycle %0d want 1 1", wc, wy); end
    tests_run++;
    if (rc !== 2) begin tests_failed++; $display("FAIL sw_latency: got %0d want 2", rc); end
    access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rc, e, rd, wc, wy, wd, wa);
    tests_run++;
    if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL sw_readback: got %08h want DEADBEEF", rd); end
    exp_rdata = rd;
  endtask

  task automatic test_errors;
    int rc, wc, wy; logic e; logic [31:0] rd, wd, wa;
    logic        ew [3];
    logic [1:0]  es [3];
    logic [31:0] ea [3];
    ew = '{1'b0, 1'b1, 1'b0};
    es = '{2'b10, 2'b01, 2'b11};
    ea = '{32'h06, 32'h41, 32'h44};
    for (int i = 0; i < 3; i++) begin
      access(ew[i], es[i], 1'b1, ea[i], 32'h12345678, rc, e, rd, wc, wy, wd, wa);
      tests_run++;
      if (rc !== 1 || e !== 1'b1) begin tests_failed++; $display("FAIL err_%0d_resp: cycle %0d err %0b want 1 1", i, rc, e); end
      tests_run++;
      if (wc !== 0) begin tests_failed++; $display("FAIL err_%0d_no_write: we_count %0d want 0", i, wc); end
      tests_run++;
      if (rd !== exp_rdata) begin tests_failed++; $display("FAIL err_%0d_rdata: got %08h want %08h", i, rd, exp_rdata); end
    end
    tests_run++;
    if (dmem[16] !== ref_word(32'h40)) begin tests_failed++; $display("FAIL err_mem_intact: got %08h want %08h", dmem[16], ref_word(32'h40)); end
  endtask

  task automatic test_reset_midop;
    int wc;
    wc = 0;
    preload(32'h30, 32'hCAFEF00D);
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b00; bus.sgn = 1'b0;
    bus.addr = 32'h31; bus.wdata = 32'h0000005A;
    @(negedge clk);
    if (mem_we) wc++;
    reset = 1'b1;
    #1;
    tests_run++;
    if (mem_we !== 1'b0 || bus.ready !== 1'b0 || bus.err !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_outputs: we %0b ready %0b err %0b want 0 0 0", mem_we, bus.ready, bus.err);
    end
    tests_run++;
    if (bus.rdata !== 32'h0 || mem_a !== 32'h0) begin
      tests_failed++; $display("FAIL midrst_regs: rdata %08h mem_a %08h want 0 0", bus.rdata, mem_a);
    end
    bus.req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_we) wc++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_we) wc++;
    end
    exp_rdata = 32'h0;
    tests_run++;
    if (wc !== 0) begin tests_failed++; $display("FAIL midrst_no_write: we_count %0d want 0", wc); end
    tests_run++;
    if (dmem[12] !== 32'hCAFEF00D) begin tests_failed++; $display("FAIL midrst_mem: got %08h want CAFEF00D", dmem[12]); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  sz [3];
    logic        sg [3];
    logic [31:0] ad [3];
    logic [31:0] ex;
    int          rcy [3];
    int          nready, idx;
    logic        pend;
    for (int i = 0; i < 3; i++) begin
      sz[i] = 2'($urandom_range(0, 2));
      sg[i] = 1'($urandom_range(0, 1));
      ad[i] = 32'($urandom_range(0, 255));
      if (sz[i] == 2'b01) ad[i][0] = 1'b0;
      if (sz[i] == 2'b10) ad[i][1:0] = 2'b00;
    end
    nready = 0; idx = 0; pend = 1'b0; ex = '0;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = sz[0]; bus.sgn = sg[0];
    bus.addr = ad[0]; bus.wdata = 32'h0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        tests_run++;
        if (bus.rdata !== ex) begin tests_failed++; $display("FAIL b2b_rdata_%0d: got %08h want %08h", idx - 1, bus.rdata, ex); end
      end
      if (bus.ready) begin
        if (nready < 3) rcy[nready] = k;
        nready++;
        ex   = ref_load(sz[idx], sg[idx], ad[idx]);
        pend = 1'b1;
        idx++;
        if (idx < 3) begin
          bus.size = sz[idx]; bus.sgn = sg[idx]; bus.addr = ad[idx];
        end else begin
          bus.req = 1'b0;
        end
      end
    end
    bus.req = 1'b0;
    exp_rdata = ex;
    tests_run++;
    if (nready !== 3) begin tests_failed++; $display("FAIL b2b_count: got %0d want 3", nready); end
    else begin
      tests_run++;
      if (rcy[0] !== 2 || rcy[1] !== 5 || rcy[2] !== 8) begin
        tests_failed++; $display("FAIL b2b_timing: got %0d %0d %0d want 2 5 8", rcy[0], rcy[1], rcy[2]);
      end
    end
  endtask

  task automatic test_random;
    int rc, wc, wy; logic e; logic [31:0] rd, wd, wa;
    logic w, sg; logic [1:0] sz; logic [31:0] a, d, ew;
    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      d  = $urandom;
      access(w, sz, sg, a, d, rc, e, rd, wc, wy, wd, wa);
      if (ref_misaligned(sz, a)) begin
        tests_run++;
        if (rc !== 1 || e !== 1'b1 || wc !== 0 || rd !== exp_rdata) begin
          tests_failed++; $display("FAIL rnd_%0d_err: cyc %0d err %0b we %0d rdata %08h want 1 1 0 %08h", n, rc, e, wc, rd, exp_rdata);
        end
      end else if (!w) begin
        exp_rdata = ref_load(sz, sg, a);
        tests_run++;
        if (rc !== 2 || e !== 1'b0 || wc !== 0 || rd !== exp_rdata) begin
          tests_failed++; $display("FAIL rnd_%0d_load: cyc %0d err %0b we %0d rdata %08h want 2 0 0 %08h", n, rc, e, wc, rd, exp_rdata);
        end
      end else begin
        ref_store(sz, a, d);
        ew = ref_word(a);
        tests_run++;
        if (rc !== ((sz == 2'b10) ? 2 : 3) || e !== 1'b0 || wc !== 1 || wy !== ((sz == 2'b10) ? 1 : 2)) begin
          tests_failed++; $display("FAIL rnd_%0d_store_timing: ready %0d err %0b we %0d at %0d sz %0d", n, rc, e, wc, wy, sz);
        end
        tests_run++;
        if (wd !== ew || wa !== {a[31:2], 2'b00} || rd !== exp_rdata) begin
          tests_failed++; $display("FAIL rnd_%0d_store_data: wd %08h a %08h rdata %08h want %08h %08h %08h", n, wd, wa, rd, ew, {a[31:2], 2'b00}, exp_rdata);
        end
      end
    end
    for (int i = 0; i < 64; i++) begin
      tests_run++;
      if (dmem[i] !== ref_word(32'(i * 4))) begin tests_failed++; $display("FAIL rnd_mem_%0d: got %08h want %08h", i, dmem[i], ref_word(32'(i * 4))); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    bd_we     = 1'b0;
    bd_idx    = '0;
    bd_val    = '0;
    bus.req   = 1'b0;
    bus.wr    = 1'b0;
    bus.size  = 2'b00;
    bus.sgn   = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    exp_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset;
    for (int i = 0; i < 64; i++) preload(32'(i * 4), $urandom);
    @(negedge clk);
    reset = 1'b0;
    test_reset;
    test_load;
    test_subword_store;
    test_word_store;
    test_errors;
    test_reset_midop;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
